alu_iter: RTL and testbench
===========================

// Module: alu_iter
// PURPOSE
//  Parametrised WIDTH-bit execute-stage ALU; successor to the bit-slice ALU. Logic/arith/compare ops
//  complete in 1 cycle; shifts iterate 1 bit/cycle; optional shift-add multiply. valid/ready on input
//  and output; single transaction in flight. Sits between decode/operand-fetch and writeback.
// PARAMETERS
//  WIDTH   32   operand/result width (>=4)
//  SHW     $clog2(WIDTH)   shift-amount width (derived, localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept (high only in IDLE)
//  op         in   4      operation code (see alu_pkg)
//  a, b       in   WIDTH  operands; shift amount = b[SHW-1:0]
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  cout       out  1      adder carry-out (ADD/SUB only, else 0)
//  overflow   out  1      signed overflow (ADD/SUB only, else 0)
//  illegal    out  1      op not supported; result forced 0
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1 after reset deasserts; out_valid, result, zero(=1), cout, overflow, illegal = 0
//   except zero, which is 1 because result=0. Async reset mid-op aborts it; no result ever emitted.
//  Ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT,
//   1000 SLTU, 1001 MUL, 1100 NOR, 1101 SRA; all other codes illegal.
//  FSM: IDLE -(in_valid)-> DONE for 1-cycle ops/illegal; -> SHIFT for SLL/SRL/SRA with shamt!=0,
//   shamt==0 goes straight to DONE with result=a; -> MUL for MUL. SHIFT: shifts 1 bit/cycle,
//   counter decrements; on count==1, -> DONE. MUL: WIDTH iterations, then DONE.
//   DONE: out_valid=1; -(out_ready)-> IDLE. Result/flags stable while out_valid && !out_ready.
//  Latency (accept edge to out_valid): 1-cycle ops 1; shift shamt+1 (shamt=0: 1); MUL WIDTH+1.
//  Capture: a, b, op registered on in_valid && in_ready; inputs ignored otherwise.
//  Arithmetic: SUB = a + ~b + 1; cout = carry-out (1 = no borrow); overflow = carry into MSB ^ cout.
//   SLT = sign(a-b) ^ overflow; SLTU = ~cout of a-b; both zero-extended to WIDTH.
//   SRA replicates a[WIDTH-1]; ADD/SUB wrap modulo 2^WIDTH.
//  MUL: unsigned shift-add; result = low WIDTH bits of product; cout/overflow = 0.
//  Back-to-back: the earliest next accept is the cycle after the out_valid && out_ready handshake
//   (in_ready rises in IDLE); there is no accept in the handshake cycle itself.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL (1001) executes as above.
//  ALU_MUL_EN undefined: 1001 is illegal (1 cycle, result 0, illegal=1); no multiplier state or logic.
// STRUCTURE
//  alu_pkg: op code localparams/enum, FSM state enum (IDLE, SHIFT, MUL, DONE).
//  Sub-module alu_addsub: combinational WIDTH-bit add/sub (a, b, sub -> sum, cout, overflow).
//   Used for ADD, SUB, SLT, SLTU and the MUL partial-sum accumulate.
// TESTING  (WIDTH=32)
//  ADD a=FFFFFFFF b=1 -> result 0, zero=1, cout=1, overflow=0, latency 1.
//  SUB a=80000000 b=1 -> 7FFFFFFF, overflow=1; SLT a=-1 b=1 -> 1; SLTU a=-1 b=1 -> 0.
//  SRA a=80000000 b=31 -> FFFFFFFF after 32 cycles; SLL shamt=0 -> a after 1 cycle.
//  Hold out_ready=0 for 5 cycles after a result -> out_valid, result stable; in_ready=0; new in_valid ignored.
//  Assert rst mid-SHIFT (shamt=20, cycle 5) -> immediate IDLE, out_valid=0, no stale result later.
//  MUL 0x0001_0003 * 0x0000_0005 -> 0x0005_000F at WIDTH+1; without ALU_MUL_EN -> illegal=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Package for the iterative execute-stage ALU.
// Holds the operation codes, the FSM state encoding and a small helper that
// picks out the shift operations.
// Optional feature: the ALU_MUL_EN macro, used in alu_iter.sv, enables MUL (4'b1001).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_NOR  = 4'b1100,
    OP_SRA  = 4'b1101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Handshake and operand/result bundle for the iterative ALU.
//   master : producer side (drives in_valid/op/a/b, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result and flags)
interface alu_if #(parameter int WIDTH = 32);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow, illegal
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor.
//   a, b     : operands
//   sub      : 1 -> a + ~b + 1, 0 -> a + b
//   sum      : result modulo 2^WIDTH
//   cout     : carry out of the MSB (for subtract, 1 means no borrow)
//   overflow : signed overflow, carry into the MSB xor carry out
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;
  logic             c_msb;

  assign bx = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB can be recovered.
  assign c_msb    = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];
  assign overflow = c_msb ^ cout;

endmodule

// File: rtl/alu_iter.sv
// Iterative execute-stage ALU with valid/ready on both sides; one transaction
// in flight. Logic, arithmetic and compare ops take one cycle; shifts move one
// bit per cycle; MUL (when ALU_MUL_EN is defined) is a WIDTH-step shift-add.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : alu_if.slave (in_valid/in_ready/op/a/b, out_valid/out_ready,
//          result, zero, cout, overflow, illegal)
// Macro: ALU_MUL_EN -- when undefined, op 1001 is reported as illegal.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // counter must also hold WIDTH for MUL

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q, ovf_q, ill_q;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_sub, as_cout, as_ovf;

  logic [WIDTH-1:0] one_res;
  logic             one_cout, one_ovf, one_ill;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mplier_q;
`endif

  assign shamt = bus.b[SHW-1:0];

  // The single adder serves the incoming op in IDLE and the partial-sum
  // accumulate while multiplying.
  always_comb begin
    as_a   = bus.a;
    as_b   = bus.b;
    as_sub = (bus.op == OP_SUB) || (bus.op == OP_SLT) || (bus.op == OP_SLTU);
`ifdef ALU_MUL_EN
    if (state_q == ST_MUL) begin
      as_a   = res_q;
      as_b   = mcand_q;
      as_sub = 1'b0;
    end
`endif
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (as_a),
    .b        (as_b),
    .sub      (as_sub),
    .sum      (as_sum),
    .cout     (as_cout),
    .overflow (as_ovf)
  );

  // Result of the op presented on the bus; shifts load the unshifted operand.
  always_comb begin
    one_res  = '0;
    one_cout = 1'b0;
    one_ovf  = 1'b0;
    one_ill  = 1'b0;
    case (bus.op)
      OP_AND:  one_res = bus.a & bus.b;
      OP_OR:   one_res = bus.a | bus.b;
      OP_XOR:  one_res = bus.a ^ bus.b;
      OP_NOR:  one_res = ~(bus.a | bus.b);
      OP_ADD, OP_SUB: begin
        one_res  = as_sum;
        one_cout = as_cout;
        one_ovf  = as_ovf;
      end
      OP_SLT:  one_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_SLTU: one_res = {{(WIDTH-1){1'b0}}, ~as_cout};
      OP_SLL, OP_SRL, OP_SRA: one_res = bus.a;
`ifdef ALU_MUL_EN
      OP_MUL:  one_res = '0;
`endif
      default: one_ill = 1'b1;
    endcase
  end

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_shift(bus.op) && (shamt != '0)) state_d = ST_SHIFT;
`ifdef ALU_MUL_EN
          else if (bus.op == OP_MUL)            state_d = ST_MUL;
`endif
          else                                  state_d = ST_DONE;
        end
      end
      ST_SHIFT: if (cnt_q == CW'(1)) state_d = ST_DONE;
`ifdef ALU_MUL_EN
      ST_MUL:   if (cnt_q == CW'(1)) state_d = ST_DONE;
`endif
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- result and flag registers (visible outputs, reset) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          res_q  <= one_res;
          cout_q <= one_cout;
          ovf_q  <= one_ovf;
          ill_q  <= one_ill;
        end
        ST_SHIFT: begin
          case (op_q)
            OP_SLL:  res_q <= {res_q[WIDTH-2:0], 1'b0};
            OP_SRL:  res_q <= {1'b0, res_q[WIDTH-1:1]};
            default: res_q <= {res_q[WIDTH-1], res_q[WIDTH-1:1]};
          endcase
        end
`ifdef ALU_MUL_EN
        ST_MUL: if (mplier_q[0]) res_q <= as_sum;
`endif
        default: ;
      endcase
    end
  end

  // ---- iteration working registers (no reset needed; loaded on accept) ----
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.in_valid) begin
      op_q  <= bus.op;
      cnt_q <= CW'(shamt);
`ifdef ALU_MUL_EN
      mcand_q  <= bus.a;
      mplier_q <= bus.b;
      if (bus.op == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
    end else if (state_q == ST_SHIFT) begin
      cnt_q <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
    end else if (state_q == ST_MUL) begin
      cnt_q    <= cnt_q - CW'(1);
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == '0);
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at WIDTH=32.
module tb_alu_iter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_if #(.WIDTH(32)) bus ();

  alu_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op, wait for acceptance, then count edges (accept edge = 1)
  // until out_valid is seen. Bounded so a stuck DUT cannot hang the run.
  task automatic run_op(input op_e o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    bus.op = o; bus.a = va; bus.b = vb; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.result !== 32'h0)   begin n_err++; $display("FAIL reset result got %h want 0", bus.result); end
    n_vec++; if ({bus.zero, bus.cout, bus.overflow, bus.illegal} !== 4'b1000)
      begin n_err++; $display("FAIL reset flags z/c/v/i got %b want 1000", {bus.zero, bus.cout, bus.overflow, bus.illegal}); end
  endtask

  task automatic test_logic();
    int lat;
    run_op(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    n_vec++; if (bus.result !== 32'hF000F000 || lat != 1) begin n_err++; $display("FAIL and got %h lat %0d want f000f000 lat 1", bus.result, lat); end
    release_result();
    run_op(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    n_vec++; if (bus.result !== 32'hFFF0FFF0) begin n_err++; $display("FAIL or got %h want fff0fff0", bus.result); end
    release_result();
    run_op(OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    n_vec++; if (bus.result !== 32'h0FF00FF0) begin n_err++; $display("FAIL xor got %h want 0ff00ff0", bus.result); end
    release_result();
    run_op(OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    n_vec++; if (bus.result !== 32'h000F000F || {bus.cout, bus.overflow} !== 2'b00)
      begin n_err++; $display("FAIL nor got %h c/v %b want 000f000f 00", bus.result, {bus.cout, bus.overflow}); end
    release_result();
  endtask

  task automatic test_addsub();
    int lat;
    run_op(OP_ADD, 32'hFFFFFFFF, 32'h1, lat);
    n_vec++; if ({bus.result, bus.zero, bus.cout, bus.overflow} !== {32'h0, 3'b110} || lat != 1)
      begin n_err++; $display("FAIL add_wrap got %h z/c/v %b lat %0d want 0 110 lat 1", bus.result, {bus.zero, bus.cout, bus.overflow}, lat); end
    release_result();
    run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat);
    n_vec++; if ({bus.result, bus.cout, bus.overflow} !== {32'h80000000, 2'b01})
      begin n_err++; $display("FAIL add_ovf got %h c/v %b want 80000000 01", bus.result, {bus.cout, bus.overflow}); end
    release_result();
    run_op(OP_SUB, 32'h80000000, 32'h1, lat);
    n_vec++; if ({bus.result, bus.zero, bus.cout, bus.overflow} !== {32'h7FFFFFFF, 3'b011})
      begin n_err++; $display("FAIL sub_ovf got %h z/c/v %b want 7fffffff 011", bus.result, {bus.zero, bus.cout, bus.overflow}); end
    release_result();
    run_op(OP_SUB, 32'h5, 32'h7, lat);
    n_vec++; if ({bus.result, bus.cout, bus.overflow} !== {32'hFFFFFFFE, 2'b00})
      begin n_err++; $display("FAIL sub_borrow got %h c/v %b want fffffffe 00", bus.result, {bus.cout, bus.overflow}); end
    release_result();
  endtask

  task automatic test_compare();
    int lat;
    run_op(OP_SLT, 32'hFFFFFFFF, 32'h1, lat);
    n_vec++; if ({bus.result, bus.cout, bus.overflow} !== {32'h1, 2'b00}) begin n_err++; $display("FAIL slt_neg got %h c/v %b want 1 00", bus.result, {bus.cout, bus.overflow}); end
    release_result();
    run_op(OP_SLTU, 32'hFFFFFFFF, 32'h1, lat);
    n_vec++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL sltu_big got %h z %b want 0 1", bus.result, bus.zero); end
    release_result();
    run_op(OP_SLT, 32'h1, 32'hFFFFFFFF, lat);
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL slt_pos got %h want 0", bus.result); end
    release_result();
    run_op(OP_SLTU, 32'h1, 32'hFFFFFFFF, lat);
    n_vec++; if (bus.result !== 32'h1) begin n_err++; $display("FAIL sltu_small got %h want 1", bus.result); end
    release_result();
  endtask

  task automatic test_shift();
    int lat;
    run_op(OP_SRA, 32'h80000000, 32'd31, lat);
    n_vec++; if (bus.result !== 32'hFFFFFFFF || lat != 32) begin n_err++; $display("FAIL sra31 got %h lat %0d want ffffffff lat 32", bus.result, lat); end
    release_result();
    run_op(OP_SLL, 32'h12345678, 32'd0, lat);
    n_vec++; if (bus.result !== 32'h12345678 || lat != 1) begin n_err++; $display("FAIL sll0 got %h lat %0d want 12345678 lat 1", bus.result, lat); end
    release_result();
    run_op(OP_SRL, 32'h80000000, 32'd4, lat);
    n_vec++; if (bus.result !== 32'h08000000 || lat != 5) begin n_err++; $display("FAIL srl4 got %h lat %0d want 08000000 lat 5", bus.result, lat); end
    release_result();
    run_op(OP_SLL, 32'h00000001, 32'd31, lat);
    n_vec++; if (bus.result !== 32'h80000000 || lat != 32) begin n_err++; $display("FAIL sll31 got %h lat %0d want 80000000 lat 32", bus.result, lat); end
    release_result();
    run_op(OP_SRL, 32'hF0000000, 32'hFFFFFFE1, lat);
    n_vec++; if (bus.result !== 32'h78000000 || lat != 2) begin n_err++; $display("FAIL srl_shamt_field got %h lat %0d want 78000000 lat 2", bus.result, lat); end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    bad = 0;
    run_op(OP_ADD, 32'd5, 32'd7, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.op = OP_XOR; bus.a = 32'hDEADBEEF; bus.b = 32'h1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd12 || bus.in_ready !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles want 0 (last %h)", bad, bus.result); end
    @(negedge clk); bus.in_valid = 1'b0;
    release_result();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); end
    bad = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) bad++; end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_ignored got %0d spurious results want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(OP_ADD, 32'd1, 32'd2, lat);
    n_vec++; if (bus.result !== 32'd3) begin n_err++; $display("FAIL b2b_first got %h want 3", bus.result); end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.op = OP_AND; bus.a = 32'hFF; bus.b = 32'h0F;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_handshake out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h0F) begin n_err++; $display("FAIL b2b_second out_valid %b result %h want 1 0000000f", bus.out_valid, bus.result); end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clk);
    bus.op = OP_SLL; bus.a = 32'h1; bus.b = 32'd20; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0)
      begin n_err++; $display("FAIL rst_mid out_valid %b in_ready %b result %h want 0 1 0", bus.out_valid, bus.in_ready, bus.result); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_stale got %0d cycles of out_valid want 0", seen); end
  endtask

  task automatic test_mul();
    int lat;
    run_op(OP_MUL, 32'h00010003, 32'h00000005, lat);
`ifdef ALU_MUL_EN
    n_vec++; if (bus.result !== 32'h0005000F || lat != 33 || bus.illegal !== 1'b0 || {bus.cout, bus.overflow} !== 2'b00)
      begin n_err++; $display("FAIL mul got %h lat %0d ill %b c/v %b want 0005000f lat 33 0 00", bus.result, lat, bus.illegal, {bus.cout, bus.overflow}); end
`else
    n_vec++; if (bus.result !== 32'h0 || lat != 1 || bus.illegal !== 1'b1)
      begin n_err++; $display("FAIL mul_disabled got %h lat %0d ill %b want 0 lat 1 1", bus.result, lat, bus.illegal); end
`endif
    release_result();
  endtask

  task automatic test_illegal();
    int lat;
    run_op(op_e'(4'b1010), 32'h5, 32'h3, lat);
    n_vec++; if ({bus.result, bus.zero, bus.illegal} !== {32'h0, 2'b11} || lat != 1)
      begin n_err++; $display("FAIL illegal_1010 got %h z/i %b lat %0d want 0 11 lat 1", bus.result, {bus.zero, bus.illegal}, lat); end
    release_result();
    run_op(OP_OR, 32'h5, 32'h3, lat);
    n_vec++; if (bus.result !== 32'h7 || bus.illegal !== 1'b0) begin n_err++; $display("FAIL illegal_clear got %h ill %b want 7 0", bus.result, bus.illegal); end
    release_result();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = OP_AND;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_logic();
    test_addsub();
    test_compare();
    test_shift();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    test_mul();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
